// File: rtl/ctrl_pkt_pkg.sv
// Shared constants for the control packet parser: FSM encodings, header
// field offsets and the full-beat byte-enable pattern.
package ctrl_pkt_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HDR     = 2'd1;
   localparam logic [1:0] ST_PAYLOAD = 2'd2;
   localparam logic [1:0] ST_DRAIN   = 2'd3;

   localparam int MOD_LSB = 80;
   localparam int RES_LSB = 88;
   localparam int IDX_LSB = 96;

   localparam logic [31:0] TKEEP_FULL = '1;

endpackage

// File: rtl/ctrl_sat_counter.sv
// Saturating event counter with synchronous active-high reset; holds at all
// ones instead of wrapping.
module ctrl_sat_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (areset) begin
         count <= '0;
      end else if (inc && !(&count)) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/ctrl_pkt_parser.sv
// Turns control packets into table write commands: beat 1 is the header,
// every full payload beat after it becomes one registered write.
// Statistics counters are built only when CTRL_PKT_STATS_EN is defined.
module ctrl_pkt_parser
   import ctrl_pkt_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int ADDR_WIDTH           = 8,
   parameter int CNT_WIDTH            = 32
) (
   input  logic                              clk,
   input  logic                              areset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
   input  logic                              ctrl_s_axis_tvalid,
   input  logic                              ctrl_s_axis_tlast,
   output logic                              cfg_wr_valid,
   output logic [7:0]                        cfg_wr_module,
   output logic [3:0]                        cfg_wr_resource,
   output logic [ADDR_WIDTH-1:0]             cfg_wr_addr,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    cfg_wr_data,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   cfg_wr_tuser,
   output logic                              cfg_wr_last,
   output logic [CNT_WIDTH-1:0]              stat_pkts,
   output logic [CNT_WIDTH-1:0]              stat_writes,
   output logic [CNT_WIDTH-1:0]              stat_errs
);

   logic [1:0]                      state;
   logic [ADDR_WIDTH-1:0]           addr_cnt;
   logic                            ovf;
   logic                            resync;
   logic                            in_pkt;
   logic [7:0]                      hdr_mod_p0;
   logic [3:0]                      hdr_res_p0;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_p0;
   logic                            keep_full;
   logic                            wr_fire;
   logic                            pkt_inc;
   logic                            err_inc;

   assign keep_full = (ctrl_s_axis_tkeep == TKEEP_FULL);

   always_comb begin
      wr_fire = 1'b0;
      pkt_inc = 1'b0;
      err_inc = 1'b0;
      if (ctrl_s_axis_tvalid) begin
         case (state)
            ST_IDLE: err_inc = !resync && ctrl_s_axis_tlast;
            ST_HDR:  err_inc = ctrl_s_axis_tlast;
            ST_PAYLOAD: begin
               wr_fire = keep_full && !ovf;
               err_inc = ovf || !keep_full;
               pkt_inc = ctrl_s_axis_tlast && !ovf;
            end
            default: ;
         endcase
      end
   end

   // in_pkt follows stream framing regardless of reset, so a reset that cuts
   // a packet can skip its remaining beats instead of misreading them.
   always_ff @(posedge clk) begin
      if (ctrl_s_axis_tvalid) begin
         in_pkt <= !ctrl_s_axis_tlast;
         if (state == ST_IDLE && !resync)
            tuser_p0 <= ctrl_s_axis_tuser;
         if (state == ST_HDR) begin
            hdr_mod_p0 <= ctrl_s_axis_tdata[MOD_LSB +: 8];
            hdr_res_p0 <= ctrl_s_axis_tdata[RES_LSB +: 4];
         end
      end
   end

   // Stage p1: registered write command and FSM
   always_ff @(posedge clk) begin
      if (areset) begin
         state           <= ST_IDLE;
         resync          <= in_pkt;
         addr_cnt        <= '0;
         ovf             <= 1'b0;
         cfg_wr_valid    <= 1'b0;
         cfg_wr_module   <= '0;
         cfg_wr_resource <= '0;
         cfg_wr_addr     <= '0;
         cfg_wr_data     <= '0;
         cfg_wr_tuser    <= '0;
         cfg_wr_last     <= 1'b0;
      end else begin
         cfg_wr_valid <= wr_fire;
         if (wr_fire) begin
            cfg_wr_module   <= hdr_mod_p0;
            cfg_wr_resource <= hdr_res_p0;
            cfg_wr_addr     <= addr_cnt;
            cfg_wr_data     <= ctrl_s_axis_tdata;
            cfg_wr_tuser    <= tuser_p0;
            cfg_wr_last     <= ctrl_s_axis_tlast;
            addr_cnt        <= addr_cnt + ADDR_WIDTH'(1);
            if (&addr_cnt)
               ovf <= 1'b1;
         end
         if (ctrl_s_axis_tvalid) begin
            case (state)
               ST_IDLE: begin
                  if (resync) begin
                     if (ctrl_s_axis_tlast)
                        resync <= 1'b0;
                  end else if (!ctrl_s_axis_tlast) begin
                     state <= ST_HDR;
                  end
               end
               ST_HDR: begin
                  addr_cnt <= ctrl_s_axis_tdata[IDX_LSB +: ADDR_WIDTH];
                  ovf      <= 1'b0;
                  state    <= ctrl_s_axis_tlast ? ST_IDLE : ST_PAYLOAD;
               end
               ST_PAYLOAD: begin
                  if (ctrl_s_axis_tlast)
                     state <= ST_IDLE;
                  else if (ovf)
                     state <= ST_DRAIN;
               end
               default: begin
                  if (ctrl_s_axis_tlast)
                     state <= ST_IDLE;
               end
            endcase
         end
      end
   end

`ifdef CTRL_PKT_STATS_EN
   ctrl_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_pkts (
      .clk(clk), .areset(areset), .inc(pkt_inc), .count(stat_pkts)
   );
   ctrl_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_writes (
      .clk(clk), .areset(areset), .inc(wr_fire), .count(stat_writes)
   );
   ctrl_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_errs (
      .clk(clk), .areset(areset), .inc(err_inc), .count(stat_errs)
   );
`else
   logic unused_stats;
   assign unused_stats = ^{pkt_inc, err_inc};
   assign stat_pkts    = '0;
   assign stat_writes  = '0;
   assign stat_errs    = '0;
`endif

endmodule

// File: tb/tb_ctrl_pkt_parser.sv
// Directed bench for ctrl_pkt_parser; statistics expectations follow
// whether CTRL_PKT_STATS_EN is defined for the build.
module tb_ctrl_pkt_parser;

   logic         clk = 1'b0;
   logic         areset;
   logic [255:0] tdata;
   logic [31:0]  tkeep;
   logic [127:0] tuser;
   logic         tvalid;
   logic         tlast;
   logic         cfg_wr_valid;
   logic [7:0]   cfg_wr_module;
   logic [3:0]   cfg_wr_resource;
   logic [7:0]   cfg_wr_addr;
   logic [255:0] cfg_wr_data;
   logic [127:0] cfg_wr_tuser;
   logic         cfg_wr_last;
   logic [31:0]  stat_pkts, stat_writes, stat_errs;

   int total = 0;
   int bad   = 0;
   int exp_pkts = 0, exp_writes = 0, exp_errs = 0;

`ifdef CTRL_PKT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [31:0]  FULL = 32'hFFFF_FFFF;
   localparam logic [127:0] U_A  = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [127:0] U_X  = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001;

   always #5 clk = ~clk;

   ctrl_pkt_parser dut (
      .clk(clk), .areset(areset),
      .ctrl_s_axis_tdata(tdata), .ctrl_s_axis_tkeep(tkeep),
      .ctrl_s_axis_tuser(tuser), .ctrl_s_axis_tvalid(tvalid),
      .ctrl_s_axis_tlast(tlast),
      .cfg_wr_valid(cfg_wr_valid), .cfg_wr_module(cfg_wr_module),
      .cfg_wr_resource(cfg_wr_resource), .cfg_wr_addr(cfg_wr_addr),
      .cfg_wr_data(cfg_wr_data), .cfg_wr_tuser(cfg_wr_tuser),
      .cfg_wr_last(cfg_wr_last),
      .stat_pkts(stat_pkts), .stat_writes(stat_writes), .stat_errs(stat_errs)
   );

   function automatic logic [255:0] hdr(input logic [7:0] m, input logic [3:0] r,
                                        input logic [7:0] idx);
      logic [255:0] d;
      d = {8{32'h5A5A_A5A5}};
      d[87:80]  = m;
      d[91:88]  = r;
      d[95:92]  = 4'hF;
      d[103:96] = idx;
      return d;
   endfunction

   function automatic logic [255:0] pay(input logic [31:0] n);
      logic [31:0] w;
      w = 32'hD000_0000 + n;
      return {8{w}};
   endfunction

   task automatic drive(input logic [255:0] d, input logic [31:0] k, input logic l,
                        input logic [127:0] u);
      tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
      @(posedge clk); #1;
      tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      tvalid = 1'b0;
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      areset = 1'b1; tvalid = 1'b1; tlast = 1'b1; tkeep = FULL;
      tdata = '0; tuser = '0;
      @(posedge clk); #1;
      tvalid = 1'b0; tlast = 1'b0;
      repeat (2) @(posedge clk); #1;
      areset = 1'b0;
      total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", cfg_wr_valid); end
      total++; if (cfg_wr_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h want=00", cfg_wr_addr); end
      total++; if (cfg_wr_data !== 256'h0) begin bad++; $display("FAIL rst_data got=%h want=0", cfg_wr_data); end
      total++; if ({cfg_wr_module, cfg_wr_resource, cfg_wr_last} !== 13'h0) begin bad++; $display("FAIL rst_fields got=%h want=0", {cfg_wr_module, cfg_wr_resource, cfg_wr_last}); end
      total++; if ({stat_pkts, stat_writes, stat_errs} !== 96'h0) begin bad++; $display("FAIL rst_stats got=%h want=0", {stat_pkts, stat_writes, stat_errs}); end
   endtask

   task automatic test_nominal(input int gap);
      drive(pay(32'h99), FULL, 1'b0, U_A); idle(gap);
      total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL nom%0d_b0_valid got=%0b want=0", gap, cfg_wr_valid); end
      drive(hdr(8'h03, 4'h2, 8'h10), FULL, 1'b0, U_X);
      total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL nom%0d_hdr_valid got=%0b want=0", gap, cfg_wr_valid); end
      idle(gap);
      drive(pay(32'h0), FULL, 1'b0, U_X);
      total++; if (cfg_wr_valid !== 1'b1) begin bad++; $display("FAIL nom%0d_w0_valid got=%0b want=1", gap, cfg_wr_valid); end
      total++; if (cfg_wr_addr !== 8'h10) begin bad++; $display("FAIL nom%0d_w0_addr got=%h want=10", gap, cfg_wr_addr); end
      total++; if (cfg_wr_data !== pay(32'h0)) begin bad++; $display("FAIL nom%0d_w0_data got=%h want=%h", gap, cfg_wr_data, pay(32'h0)); end
      total++; if ({cfg_wr_module, cfg_wr_resource, cfg_wr_last} !== {8'h03, 4'h2, 1'b0}) begin bad++; $display("FAIL nom%0d_w0_fields got=%h want=%h", gap, {cfg_wr_module, cfg_wr_resource, cfg_wr_last}, {8'h03, 4'h2, 1'b0}); end
      total++; if (cfg_wr_tuser !== U_A) begin bad++; $display("FAIL nom%0d_w0_tuser got=%h want=%h", gap, cfg_wr_tuser, U_A); end
      idle(gap);
      if (gap > 0) begin
         total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL nom%0d_gap_valid got=%0b want=0", gap, cfg_wr_valid); end
      end
      drive(pay(32'h1), FULL, 1'b1, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr, cfg_wr_last} !== {1'b1, 8'h11, 1'b1}) begin bad++; $display("FAIL nom%0d_w1_vld_addr_last got=%h want=%h", gap, {cfg_wr_valid, cfg_wr_addr, cfg_wr_last}, {1'b1, 8'h11, 1'b1}); end
      total++; if (cfg_wr_data !== pay(32'h1)) begin bad++; $display("FAIL nom%0d_w1_data got=%h want=%h", gap, cfg_wr_data, pay(32'h1)); end
      idle(1);
      exp_pkts += 1; exp_writes += 2;
      total++; if ({cfg_wr_valid, cfg_wr_addr} !== {1'b0, 8'h11}) begin bad++; $display("FAIL nom%0d_hold got=%h want=%h", gap, {cfg_wr_valid, cfg_wr_addr}, {1'b0, 8'h11}); end
      total++; if ({stat_pkts, stat_writes, stat_errs} !== {32'(STATS ? exp_pkts : 0), 32'(STATS ? exp_writes : 0), 32'(STATS ? exp_errs : 0)}) begin bad++; $display("FAIL nom%0d_stats got=%h want=%0d/%0d/%0d", gap, {stat_pkts, stat_writes, stat_errs}, exp_pkts, exp_writes, exp_errs); end
   endtask

   task automatic test_partial_tkeep;
      drive(pay(32'h98), FULL, 1'b0, U_X);
      drive(hdr(8'h11, 4'h5, 8'h40), FULL, 1'b0, U_X);
      drive(pay(32'h20), FULL, 1'b0, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr} !== {1'b1, 8'h40}) begin bad++; $display("FAIL part_w0 got=%h want=%h", {cfg_wr_valid, cfg_wr_addr}, {1'b1, 8'h40}); end
      drive(pay(32'h21), 32'h0000_FFFF, 1'b0, U_X);
      total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL part_drop_valid got=%0b want=0", cfg_wr_valid); end
      drive(pay(32'h22), FULL, 1'b1, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr, cfg_wr_last} !== {1'b1, 8'h41, 1'b1}) begin bad++; $display("FAIL part_w1 got=%h want=%h", {cfg_wr_valid, cfg_wr_addr, cfg_wr_last}, {1'b1, 8'h41, 1'b1}); end
      total++; if (cfg_wr_data !== pay(32'h22)) begin bad++; $display("FAIL part_w1_data got=%h want=%h", cfg_wr_data, pay(32'h22)); end
      idle(1);
      exp_pkts += 1; exp_writes += 2; exp_errs += 1;
      total++; if ({stat_pkts, stat_writes, stat_errs} !== {32'(STATS ? exp_pkts : 0), 32'(STATS ? exp_writes : 0), 32'(STATS ? exp_errs : 0)}) begin bad++; $display("FAIL part_stats got=%h want=%0d/%0d/%0d", {stat_pkts, stat_writes, stat_errs}, exp_pkts, exp_writes, exp_errs); end
   endtask

   task automatic test_overflow;
      drive(pay(32'h97), FULL, 1'b0, U_X);
      drive(hdr(8'h22, 4'h7, 8'hFE), FULL, 1'b0, U_X);
      drive(pay(32'h30), FULL, 1'b0, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr} !== {1'b1, 8'hFE}) begin bad++; $display("FAIL ovf_wFE got=%h want=%h", {cfg_wr_valid, cfg_wr_addr}, {1'b1, 8'hFE}); end
      drive(pay(32'h31), FULL, 1'b0, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr} !== {1'b1, 8'hFF}) begin bad++; $display("FAIL ovf_wFF got=%h want=%h", {cfg_wr_valid, cfg_wr_addr}, {1'b1, 8'hFF}); end
      drive(pay(32'h32), FULL, 1'b0, U_X);
      total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL ovf_wrap_valid got=%0b want=0", cfg_wr_valid); end
      drive(pay(32'h33), FULL, 1'b1, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr} !== {1'b0, 8'hFF}) begin bad++; $display("FAIL ovf_drain got=%h want=%h", {cfg_wr_valid, cfg_wr_addr}, {1'b0, 8'hFF}); end
      exp_writes += 2; exp_errs += 1;
      drive(pay(32'h96), FULL, 1'b0, U_X);
      drive(hdr(8'h07, 4'h1, 8'h20), FULL, 1'b0, U_X);
      drive(pay(32'h34), FULL, 1'b1, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr, cfg_wr_module, cfg_wr_resource, cfg_wr_last} !== {1'b1, 8'h20, 8'h07, 4'h1, 1'b1}) begin bad++; $display("FAIL ovf_next_pkt got=%h want=%h", {cfg_wr_valid, cfg_wr_addr, cfg_wr_module, cfg_wr_resource, cfg_wr_last}, {1'b1, 8'h20, 8'h07, 4'h1, 1'b1}); end
      idle(1);
      exp_pkts += 1; exp_writes += 1;
      total++; if ({stat_pkts, stat_writes, stat_errs} !== {32'(STATS ? exp_pkts : 0), 32'(STATS ? exp_writes : 0), 32'(STATS ? exp_errs : 0)}) begin bad++; $display("FAIL ovf_stats got=%h want=%0d/%0d/%0d", {stat_pkts, stat_writes, stat_errs}, exp_pkts, exp_writes, exp_errs); end
   endtask

   task automatic test_short;
      drive(pay(32'h40), FULL, 1'b1, U_X);
      total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL short1_valid got=%0b want=0", cfg_wr_valid); end
      drive(pay(32'h41), FULL, 1'b0, U_X);
      drive(hdr(8'h01, 4'h1, 8'h01), FULL, 1'b1, U_X);
      total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL short2_valid got=%0b want=0", cfg_wr_valid); end
      exp_errs += 2;
      // The FSM must be back in IDLE: a well-formed 3-beat packet writes once.
      drive(pay(32'h42), FULL, 1'b0, U_X);
      drive(hdr(8'h05, 4'h3, 8'h50), FULL, 1'b0, U_X);
      drive(pay(32'h43), FULL, 1'b1, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr} !== {1'b1, 8'h50}) begin bad++; $display("FAIL short_idle_after got=%h want=%h", {cfg_wr_valid, cfg_wr_addr}, {1'b1, 8'h50}); end
      idle(1);
      exp_pkts += 1; exp_writes += 1;
      total++; if ({stat_pkts, stat_writes, stat_errs} !== {32'(STATS ? exp_pkts : 0), 32'(STATS ? exp_writes : 0), 32'(STATS ? exp_errs : 0)}) begin bad++; $display("FAIL short_stats got=%h want=%0d/%0d/%0d", {stat_pkts, stat_writes, stat_errs}, exp_pkts, exp_writes, exp_errs); end
   endtask

   task automatic test_reset_mid;
      drive(pay(32'h95), FULL, 1'b0, U_X);
      drive(hdr(8'h09, 4'h4, 8'h30), FULL, 1'b0, U_X);
      drive(pay(32'h60), FULL, 1'b0, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr} !== {1'b1, 8'h30}) begin bad++; $display("FAIL rmid_w0 got=%h want=%h", {cfg_wr_valid, cfg_wr_addr}, {1'b1, 8'h30}); end
      areset = 1'b1;
      @(posedge clk); #1;
      areset = 1'b0;
      exp_pkts = 0; exp_writes = 0; exp_errs = 0;
      total++; if ({cfg_wr_valid, cfg_wr_addr} !== 9'h0) begin bad++; $display("FAIL rmid_rst got=%h want=0", {cfg_wr_valid, cfg_wr_addr}); end
      total++; if ({stat_pkts, stat_writes, stat_errs} !== 96'h0) begin bad++; $display("FAIL rmid_stats0 got=%h want=0", {stat_pkts, stat_writes, stat_errs}); end
      for (int i = 0; i < 3; i++) begin
         drive(pay(32'h61 + 32'(i)), FULL, (i == 2), U_X);
         total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL rmid_tail%0d_valid got=%0b want=0", i, cfg_wr_valid); end
      end
      drive(pay(32'h94), FULL, 1'b0, U_A);
      drive(hdr(8'h0A, 4'h6, 8'h70), FULL, 1'b0, U_X);
      drive(pay(32'h70), FULL, 1'b1, U_X);
      total++; if ({cfg_wr_valid, cfg_wr_addr, cfg_wr_module, cfg_wr_resource} !== {1'b1, 8'h70, 8'h0A, 4'h6}) begin bad++; $display("FAIL rmid_next got=%h want=%h", {cfg_wr_valid, cfg_wr_addr, cfg_wr_module, cfg_wr_resource}, {1'b1, 8'h70, 8'h0A, 4'h6}); end
      total++; if (cfg_wr_tuser !== U_A) begin bad++; $display("FAIL rmid_tuser got=%h want=%h", cfg_wr_tuser, U_A); end
      idle(1);
      exp_pkts += 1; exp_writes += 1;
      total++; if ({stat_pkts, stat_writes, stat_errs} !== {32'(STATS ? exp_pkts : 0), 32'(STATS ? exp_writes : 0), 32'(STATS ? exp_errs : 0)}) begin bad++; $display("FAIL rmid_stats got=%h want=%0d/%0d/%0d", {stat_pkts, stat_writes, stat_errs}, exp_pkts, exp_writes, exp_errs); end
   endtask

   initial begin
      areset = 1'b1; tvalid = 1'b0; tlast = 1'b0;
      tdata = '0; tkeep = '0; tuser = '0;
      test_reset();
      test_nominal(0);
      test_nominal(3);
      test_partial_tkeep();
      test_overflow();
      test_short();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ctrl_pkt_parser.md
Name: ctrl_pkt_parser

Overview:
- Sits directly downstream of the packet filter's control output (ctrl_m_axis_*).
- Consumes control UDP packets, 256-bit beats, no back-pressure.
- Decodes the control header in beat 1 and turns each payload beat (beat 2 onward) into one configuration write command to the pipeline stages' tables (parser/key-extractor/lookup/action RAMs).
- One registered write per payload beat; no stalls.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, stream data width; field offsets are fixed for 256.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width; passed through unused except cfg_wr_tuser.
- ADDR_WIDTH, 8, table entry index width.
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk  in  1  stream clock.
- areset  in  1  synchronous, active-high reset.
- ctrl_s_axis_tdata  in  256  control beat data.
- ctrl_s_axis_tkeep  in  32  byte enables.
- ctrl_s_axis_tuser  in  128  metadata.
- ctrl_s_axis_tvalid  in  1  beat valid; there is no tready, so every valid beat is consumed.
- ctrl_s_axis_tlast  in  1  last beat of packet.
- cfg_wr_valid  out  1  one-cycle write strobe.
- cfg_wr_module  out  8  target module id.
- cfg_wr_resource  out  4  resource (table) id within the module.
- cfg_wr_addr  out  ADDR_WIDTH  entry index.
- cfg_wr_data  out  256  entry contents.
- cfg_wr_tuser  out  128  tuser of the source packet's first beat.
- cfg_wr_last  out  1  marks the final write of the packet.
- stat_pkts  out  CNT_WIDTH  control packets completed.
- stat_writes  out  CNT_WIDTH  writes issued.
- stat_errs  out  CNT_WIDTH  malformed packets or beats.

Behaviour:
- Reset: when areset=1 at a rising clk edge:
  - state returns to IDLE;
  - all cfg_wr_* outputs go to 0;
  - stat_* counters go to 0.
  - A packet in flight is abandoned with no further writes; the FSM resynchronises on the next tlast.
- A beat counts only when ctrl_s_axis_tvalid=1. tvalid gaps inside a packet hold state and all counters.
- Header fields, taken from beat 1 (second beat):
  - module = tdata[87:80];
  - resource = tdata[91:88];
  - tdata[95:92] reserved, ignored;
  - start index = tdata[103:96].
- FSM states:
  - IDLE: a valid beat with tlast=0 latches tuser → HDR. A valid beat with tlast=1 (1-beat packet) → stat_errs+1, stay IDLE.
  - HDR: a valid beat latches module, resource and index into addr_cnt. tlast=1 → stat_errs+1, IDLE. Otherwise → PAYLOAD.
  - PAYLOAD: each valid beat is handled as follows:
    - If tkeep=all ones and no overflow: issue a write. cfg_wr_valid=1 on the next cycle (latency 1), cfg_wr_addr=addr_cnt, cfg_wr_data=tdata, cfg_wr_last=tlast. addr_cnt increments after the write.
    - If tkeep≠all ones: drop the beat, stat_errs+1, addr_cnt unchanged.
    - tlast → IDLE, stat_pkts+1.
  - DRAIN: entered from PAYLOAD on overflow. Discards beats until tlast, then → IDLE with no stat_pkts increment.
- Overflow rule: a write to index 255 is allowed. The next payload beat finds addr_cnt wrapped; that beat is suppressed (no write, stat_errs+1) and the FSM goes to DRAIN. No wrap-around writes ever occur.
- cfg_wr_valid is high for exactly one cycle per accepted beat. Otherwise cfg_wr_valid=0 and the other cfg_wr_* outputs hold their last values.
- Counters saturate at all ones.
- When a write coincides with tlast, stat_writes and stat_pkts both increment in the same cycle.

Optional Feature:
- CTRL_PKT_STATS_EN defined: stat_pkts, stat_writes and stat_errs count as specified.
- Undefined: the three counters are not instantiated and the stat_* outputs are constant 0. cfg_wr_* behaviour is identical either way.

Decomposition:
- Package ctrl_pkt_pkg holds:
  - state encodings (IDLE=0, HDR=1, PAYLOAD=2, DRAIN=3);
  - header bit offsets (MOD_LSB=80, RES_LSB=88, IDX_LSB=96);
  - the all-ones TKEEP_FULL constant.
- One sub-module: ctrl_sat_counter, a CNT_WIDTH saturating counter with synchronous reset and an increment enable, instantiated three times under CTRL_PKT_STATS_EN.

Test Plan:
- Nominal: 4-beat packet, header module=0x03, resource=0x2, index=0x10, payload beats D0 and D1 → two writes, one cycle after each beat: addr 0x10 data D0 last=0, then addr 0x11 data D1 last=1. stat_pkts=1, stat_writes=2.
- tvalid gaps: same packet with 3 idle cycles between every beat → identical writes, each one cycle after its beat.
- Partial tkeep: 5-beat packet, payload beat 2 has tkeep=0x0000FFFF → writes at idx and idx+1 only (idx+1 carries beat 3's data), stat_errs=1.
- Overflow: index=0xFE, four payload beats → writes at 0xFE and 0xFF only, stat_errs=1, stat_pkts unchanged. The next packet decodes normally.
- Short packets: 1-beat packet, then 2-beat packet → no writes, stat_errs=2, state IDLE.
- Reset mid-PAYLOAD after one write: no further cfg_wr_valid, counters=0. The remaining beats of that packet produce no writes; the following packet decodes normally.
